hue_sequencer: RTL and testbench

Controller that sequences the three RGB PWM generators through a continuous six-phase colour-wheel fade. It owns phase/ramp state and a step prescaler, and hands each PWM channel a duty value. Duty values are committed only at PWM period boundaries, so a PWM period never sees a mid-period duty change. It sits in `top` between the clock and the three per-channel PWM datapaths.

---
 rtl/fade_pkg.sv | 25 ++
 rtl/step_prescaler.sv | 44 ++++
 rtl/hue_sequencer.sv | 125 ++++++++++++
 tb/tb_hue_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// fade_pkg: shared types for the colour-wheel fade sequencer.
//   phase_t    : the six fade phases, named after the channel that moves
//   NUM_PHASES : number of phases in one colour-wheel revolution
//   next_phase : successor phase, wrapping from the last back to the first
package fade_pkg;

    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } phase_t;

    localparam int unsigned NUM_PHASES = 6;

    function automatic phase_t next_phase(input phase_t ph);
        if (ph == 3'(NUM_PHASES - 1)) begin
            return PH_G_UP;
        end
        return phase_t'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: free-running divider that emits one-cycle ramp-step ticks.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   en    in  count enable; the count freezes while low
//   clear in  synchronous return of the count to zero (wins over counting)
//   tick  out high on the enabled cycle where the count sits at TICKS-1
module step_prescaler #(
    parameter int unsigned TICKS = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    assign tick = en && (r_cnt == LAST);

    always_comb begin
        w_cnt_d = r_cnt;
        if (clear) begin
            w_cnt_d = '0;
        end else if (tick) begin
            w_cnt_d = '0;
        end else if (en) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// hue_sequencer: drives three PWM duty values through a six-phase colour-wheel fade.
//   clk, rst           clock / asynchronous active-high reset
//   en                 advance prescaler and ramp when high, freeze when low
//   restart            one-cycle request back to phase 0, ramp 0
//   pwm_wrap           PWM period boundary; the only moment duties are committed
//   duty_r/g/b         committed duty per channel, 0..PWM_INTERVAL
//   phase              current phase 0..5
//   phase_done         one-cycle pulse after the edge that advanced the phase
// DW is derived from PWM_INTERVAL and must not be overridden.
module hue_sequencer
    import fade_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL   = 1200,
    parameter int unsigned DUTY_STEP      = 12,
    parameter int unsigned TICKS_PER_STEP = 20000,
    parameter int unsigned DW             = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic          pwm_wrap,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    phase,
    output logic          phase_done
);

    localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   STEP_EXT = (DW + 1)'(DUTY_STEP);

    phase_t        r_phase,      w_phase_d;
    logic [DW-1:0] r_ramp,       w_ramp_d;
    logic          r_phase_done, w_phase_done_d;
    logic [DW-1:0] r_duty_r, r_duty_g, r_duty_b;
    logic [DW-1:0] w_tgt_r,  w_tgt_g,  w_tgt_b;
    logic          w_step;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_ramp_up;
    logic [DW-1:0] w_dn;

    step_prescaler #(
        .TICKS (TICKS_PER_STEP)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (restart),
        .tick  (w_step)
    );

    // One extra bit so ramp + step cannot wrap before the saturation compare.
    assign w_sum     = {1'b0, r_ramp} + STEP_EXT;
    assign w_ramp_up = (w_sum > {1'b0, FULL}) ? FULL : w_sum[DW-1:0];
    assign w_dn      = FULL - r_ramp;

    // Phase/ramp FSM next state. Restart overrides a coincident step.
    always_comb begin
        w_phase_d      = r_phase;
        w_ramp_d       = r_ramp;
        w_phase_done_d = 1'b0;
        if (restart) begin
            w_phase_d = PH_G_UP;
            w_ramp_d  = '0;
        end else if (w_step) begin
            if (r_ramp < FULL) begin
                w_ramp_d = w_ramp_up;
            end else begin
                // A full ramp gets one extra step as a hold before the phase turns.
                w_ramp_d       = '0;
                w_phase_d      = next_phase(r_phase);
                w_phase_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= PH_G_UP;
            r_ramp       <= '0;
            r_phase_done <= 1'b0;
        end else begin
            r_phase      <= w_phase_d;
            r_ramp       <= w_ramp_d;
            r_phase_done <= w_phase_done_d;
        end
    end

    // Targets: the end of each phase equals the start of the next.
    always_comb begin
        w_tgt_r = '0;
        w_tgt_g = '0;
        w_tgt_b = '0;
        unique case (r_phase)
            PH_G_UP: begin w_tgt_r = FULL;   w_tgt_g = r_ramp; w_tgt_b = '0;     end
            PH_R_DN: begin w_tgt_r = w_dn;   w_tgt_g = FULL;   w_tgt_b = '0;     end
            PH_B_UP: begin w_tgt_r = '0;     w_tgt_g = FULL;   w_tgt_b = r_ramp; end
            PH_G_DN: begin w_tgt_r = '0;     w_tgt_g = w_dn;   w_tgt_b = FULL;   end
            PH_R_UP: begin w_tgt_r = r_ramp; w_tgt_g = '0;     w_tgt_b = FULL;   end
            PH_B_DN: begin w_tgt_r = FULL;   w_tgt_g = '0;     w_tgt_b = w_dn;   end
            default: begin w_tgt_r = FULL;   w_tgt_g = '0;     w_tgt_b = '0;     end
        endcase
    end

    // Commit only at PWM period boundaries so a period never sees a duty change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_r <= FULL;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else if (pwm_wrap) begin
            r_duty_r <= w_tgt_r;
            r_duty_g <= w_tgt_g;
            r_duty_b <= w_tgt_b;
        end
    end

    assign duty_r     = r_duty_r;
    assign duty_g     = r_duty_g;
    assign duty_b     = r_duty_b;
    assign phase      = r_phase;
    assign phase_done = r_phase_done;

endmodule

// File: tb/tb_hue_sequencer.sv
// Self-checking bench for hue_sequencer with PWM_INTERVAL=10, DUTY_STEP=4, TICKS_PER_STEP=3.
module tb_hue_sequencer;

    localparam int M  = 10;
    localparam int DS = 4;
    localparam int T  = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          restart = 1'b0;
    logic          pwm_wrap = 1'b0;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic [2:0]    phase;
    logic          phase_done;

    always #5 clk = ~clk;

    hue_sequencer #(
        .PWM_INTERVAL   (M),
        .DUTY_STEP      (DS),
        .TICKS_PER_STEP (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .pwm_wrap   (pwm_wrap),
        .duty_r     (duty_r),
        .duty_g     (duty_g),
        .duty_b     (duty_b),
        .phase      (phase),
        .phase_done (phase_done)
    );

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [2:0] ph;
        logic       pd;
    } exp_t;

    typedef struct {
        bit e;
        bit rs;
        bit w;
        int r;
        int g;
        int b;
        int ph;
        int pd;
    } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int   m_cnt, m_ramp, m_phase;
    exp_t m_out;

    function automatic exp_t sample();
        exp_t s;
        s.r  = duty_r;
        s.g  = duty_g;
        s.b  = duty_b;
        s.ph = phase;
        s.pd = phase_done;
        return s;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t ex);
        n_tests++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL %s @%0t: got r=%0d g=%0d b=%0d ph=%0d pd=%0d, expected r=%0d g=%0d b=%0d ph=%0d pd=%0d",
                     name, $time, got.r, got.g, got.b, got.ph, got.pd,
                     ex.r, ex.g, ex.b, ex.ph, ex.pd);
        end
    endtask

    task automatic check_int(input string name, input int got, input int ex);
        n_tests++;
        if (got != ex) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, ex);
        end
    endtask

    // Channel level per phase: 0 off, 1 full, 2 rising ramp, 3 falling ramp.
    function automatic int tgt(input int ph, input int ramp, input int ch);
        int lvl;
        int modes [6][3];
        modes = '{'{1, 2, 0}, '{3, 1, 0}, '{0, 1, 2}, '{0, 3, 1}, '{2, 0, 1}, '{1, 0, 3}};
        case (modes[ph][ch])
            1:       lvl = M;
            2:       lvl = ramp;
            3:       lvl = M - ramp;
            default: lvl = 0;
        endcase
        return lvl;
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_ramp  = 0;
        m_phase = 0;
        m_out   = '{r: 4'(M), g: 4'd0, b: 4'd0, ph: 3'd0, pd: 1'b0};
        q.delete();
    endtask

    task automatic model_edge(input bit e, input bit rs, input bit w);
        bit st;
        if (w) begin
            m_out.r = 4'(tgt(m_phase, m_ramp, 0));
            m_out.g = 4'(tgt(m_phase, m_ramp, 1));
            m_out.b = 4'(tgt(m_phase, m_ramp, 2));
        end
        m_out.pd = 1'b0;
        st = e && (m_cnt == T - 1);
        if (rs) begin
            m_cnt   = 0;
            m_ramp  = 0;
            m_phase = 0;
        end else begin
            if (e) m_cnt = st ? 0 : m_cnt + 1;
            if (st) begin
                if (m_ramp < M) begin
                    m_ramp = (m_ramp + DS > M) ? M : m_ramp + DS;
                end else begin
                    m_ramp   = 0;
                    m_phase  = (m_phase + 1) % 6;
                    m_out.pd = 1'b1;
                end
            end
        end
        m_out.ph = 3'(m_phase);
    endtask

    // Drive one cycle at the falling edge, predict, compare 1 time unit after the rising edge.
    task automatic tick(input bit e, input bit rs, input bit w);
        exp_t ex;
        @(negedge clk);
        en       = e;
        restart  = rs;
        pwm_wrap = w;
        model_edge(e, rs, w);
        q.push_back(m_out);
        @(posedge clk);
        #1;
        ex = q.pop_front();
        check("scoreboard", sample(), ex);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        en       = 1'b0;
        restart  = 1'b0;
        pwm_wrap = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tab[13];
    exp_t prev, cur;
    int   pd_count, max_delta, d, viol, changes, guard;
    bit   found;

    initial begin
        for (int i = 0; i < 13; i++) begin
            tab[i] = '{e: 1'b1, rs: 1'b0, w: 1'b1, r: 10, g: 0, b: 0, ph: 0, pd: 0};
            if (i >= 3)  tab[i].g = 4;
            if (i >= 6)  tab[i].g = 8;
            if (i >= 9)  tab[i].g = 10;
            if (i >= 11) tab[i].ph = 1;
        end
        tab[11].pd = 1;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", sample(), '{r: 4'd10, g: 4'd0, b: 4'd0, ph: 3'd0, pd: 1'b0});
        rst = 1'b0;

        // Hand-derived ramp sequence after reset
        for (int i = 0; i < 13; i++) begin
            tick(tab[i].e, tab[i].rs, tab[i].w);
            check($sformatf("vec%0d", i + 1), sample(),
                  '{r: 4'(tab[i].r), g: 4'(tab[i].g), b: 4'(tab[i].b),
                    ph: 3'(tab[i].ph), pd: 1'(tab[i].pd)});
        end

        // Full wheel: 72 clocks
        apply_reset();
        pd_count  = 0;
        max_delta = 0;
        prev      = sample();
        for (int i = 0; i < 72; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            cur = sample();
            if (cur.pd) pd_count++;
            d = int'(cur.r) - int'(prev.r); if (d < 0) d = -d; if (d > max_delta) max_delta = d;
            d = int'(cur.g) - int'(prev.g); if (d < 0) d = -d; if (d > max_delta) max_delta = d;
            d = int'(cur.b) - int'(prev.b); if (d < 0) d = -d; if (d > max_delta) max_delta = d;
            prev = cur;
        end
        check_int("wheel_phase_done_count", pd_count, 6);
        check_int("wheel_continuity_max_delta", (max_delta <= DS) ? 1 : 0, 1);
        check("wheel_end", sample(), '{r: 4'd10, g: 4'd0, b: 4'd0, ph: 3'd0, pd: 1'b1});

        // Sparse pwm_wrap: every fifth clock
        apply_reset();
        viol    = 0;
        changes = 0;
        prev    = sample();
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b0, (i % 5) == 4);
            cur = sample();
            if ({cur.r, cur.g, cur.b} != {prev.r, prev.g, prev.b}) begin
                if ((i % 5) != 4) viol++;
                else changes++;
            end
            prev = cur;
        end
        check_int("sparse_wrap_hold_violations", viol, 0);
        check_int("sparse_wrap_some_changes", (changes > 0) ? 1 : 0, 1);

        // en low for 7 clocks at cnt=1 in phase 2
        apply_reset();
        found = 1'b0;
        for (guard = 0; guard < 100 && !found; guard++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (m_phase == 2 && m_cnt == 1) found = 1'b1;
        end
        check_int("reach_phase2_cnt1", found ? 1 : 0, 1);
        viol = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (duty_b != 4'd0 || phase != 3'd2 || duty_r != 4'd0 || duty_g != 4'd10) viol++;
        end
        check_int("en_low_frozen", viol, 0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("en_resume_step_edge", sample(), '{r: 4'd0, g: 4'd10, b: 4'd0, ph: 3'd2, pd: 1'b0});
        tick(1'b1, 1'b0, 1'b1);
        check("en_resume_committed", sample(), '{r: 4'd0, g: 4'd10, b: 4'd4, ph: 3'd2, pd: 1'b0});

        // restart coincident with a step at phase 3, ramp 8
        apply_reset();
        found = 1'b0;
        for (guard = 0; guard < 100 && !found; guard++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (m_phase == 3 && m_ramp == 8 && m_cnt == T - 1) found = 1'b1;
        end
        check_int("reach_phase3_ramp8", found ? 1 : 0, 1);
        tick(1'b1, 1'b1, 1'b1);
        check("restart_with_step", sample(), '{r: 4'd0, g: 4'd2, b: 4'd10, ph: 3'd0, pd: 1'b0});
        tick(1'b1, 1'b0, 1'b1);
        check("restart_next_commit", sample(), '{r: 4'd10, g: 4'd0, b: 4'd0, ph: 3'd0, pd: 1'b0});
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-phase 4
        apply_reset();
        found = 1'b0;
        for (guard = 0; guard < 200 && !found; guard++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (m_phase == 4 && m_ramp == 4) found = 1'b1;
        end
        check_int("reach_phase4", found ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", sample(), '{r: 4'd10, g: 4'd0, b: 4'd0, ph: 3'd0, pd: 1'b0});
        en       = 1'b0;
        pwm_wrap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
